// File: rtl/audio_dac_if.sv
// Sample handshake between the audio source (e.g. equalizer) and the DAC serializer.
//   sample_valid    : source has a stereo sample on left/right_audio_in
//   sample_ready    : serializer can take it; transfer on valid & ready
//   left_audio_in   : left channel sample, two's complement
//   right_audio_in  : right channel sample, two's complement
interface audio_dac_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic                    sample_valid;
  logic                    sample_ready;
  logic [SAMPLE_WIDTH-1:0] left_audio_in;
  logic [SAMPLE_WIDTH-1:0] right_audio_in;

  modport master (output sample_valid, left_audio_in, right_audio_in, input sample_ready);
  modport slave  (input sample_valid, left_audio_in, right_audio_in, output sample_ready);
endinterface

// File: rtl/audio_dac_serializer.sv
// I2S transmitter for the codec DAC. Accepts stereo samples over audio_dac_if,
// keeps one sample in a holding buffer, derives BCLK/LRCK from clk and shifts
// each channel out MSB first with the I2S one-bit delay.
// Ports:
//   clk, rst     : system clock, synchronous active-low reset
//   enable       : 1 = run and accept samples, 0 = finish the current frame then idle
//   aud_in       : sample handshake (slave side)
//   aud_bclk     : codec bit clock, half-period BCLK_DIV clks
//   aud_daclrck  : 0 = left slot, 1 = right slot
//   aud_dacdat   : serial data, updated on the BCLK falling tick
//   underrun     : one-clk pulse when a frame starts with no new sample buffered
module audio_dac_serializer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 32,
  parameter int BCLK_DIV     = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  audio_dac_if.slave     aud_in,
  output logic           aud_bclk,
  output logic           aud_daclrck,
  output logic           aud_dacdat,
  output logic           underrun
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(2 * SLOT_WIDTH);
  localparam logic [DW-1:0] DIV_LAST   = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] FRAME_LAST = BW'(2 * SLOT_WIDTH - 1);
  localparam logic [BW-1:0] SLOT       = BW'(SLOT_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [DW-1:0]           div_q, div_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic                    bclk_q, bclk_d;
  logic                    lrck_q, lrck_d;
  logic                    dat_q, dat_d;
  logic                    ur_q, ur_d;
  logic                    ready_q, ready_d;
  // Transmit registers double as the "last sample" used on underrun: they are
  // read by slot bit index and never shifted, so they always hold the last pair.
  logic [SAMPLE_WIDTH-1:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;
  logic [SAMPLE_WIDTH-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic                    buf_full_q, buf_full_d;

  logic                    accept, term, fall, boundary;
  logic [BW-1:0]           slot_bit;
  logic [SAMPLE_WIDTH-1:0] smp;

  assign accept   = aud_in.sample_valid & ready_q;
  assign term     = (div_q == DIV_LAST);
  assign fall     = term & bclk_q;
  assign boundary = fall & (bit_q == FRAME_LAST);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    bclk_d     = bclk_q;
    ur_d       = 1'b0;
    tx_l_d     = tx_l_q;
    tx_r_d     = tx_r_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    buf_full_d = buf_full_q;

    case (state_q)
      IDLE: begin
        div_d  = '0;
        bit_d  = '0;
        bclk_d = 1'b0;
        if (accept) begin
          tx_l_d  = aud_in.left_audio_in;
          tx_r_d  = aud_in.right_audio_in;
          state_d = RUN;
        end else if (enable && buf_full_q) begin
          // a sample captured while draining is sent first on restart
          tx_l_d     = buf_l_q;
          tx_r_d     = buf_r_q;
          buf_full_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN, DRAIN: begin
        div_d = term ? '0 : div_q + DW'(1);
        if (term) bclk_d = ~bclk_q;
        if (fall) bit_d = (bit_q == FRAME_LAST) ? '0 : bit_q + BW'(1);
        if (boundary && state_q == DRAIN && !enable) begin
          state_d = IDLE;
        end else begin
          if (boundary) begin
            if (buf_full_q) begin
              tx_l_d     = buf_l_q;
              tx_r_d     = buf_r_q;
              buf_full_d = 1'b0;
            end else begin
              ur_d = 1'b1;
            end
          end
          state_d = enable ? RUN : DRAIN;
        end
        // boundary reload above reads the old buffer, so a same-clk accept
        // lands here for the following frame
        if (accept) begin
          buf_l_d    = aud_in.left_audio_in;
          buf_r_d    = aud_in.right_audio_in;
          buf_full_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Output bits are registered from the next bit position so they change
    // together with the BCLK falling tick.
    lrck_d   = (bit_d >= SLOT);
    slot_bit = lrck_d ? bit_d - SLOT : bit_d;
    smp      = lrck_d ? tx_r_q : tx_l_q;
    dat_d    = 1'b0;
    for (int i = 0; i < SAMPLE_WIDTH; i++)
      if (slot_bit == BW'(SAMPLE_WIDTH - i)) dat_d = smp[i];

    ready_d = enable & ~buf_full_d & (state_d != DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      bclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      dat_q      <= 1'b0;
      ur_q       <= 1'b0;
      ready_q    <= 1'b1;
      tx_l_q     <= '0;
      tx_r_q     <= '0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      buf_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      bclk_q     <= bclk_d;
      lrck_q     <= lrck_d;
      dat_q      <= dat_d;
      ur_q       <= ur_d;
      ready_q    <= ready_d;
      tx_l_q     <= tx_l_d;
      tx_r_q     <= tx_r_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      buf_full_q <= buf_full_d;
    end
  end

  assign aud_in.sample_ready = ready_q;
  assign aud_bclk    = bclk_q;
  assign aud_daclrck = lrck_q;
  assign aud_dacdat  = dat_q;
  assign underrun    = ur_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
module tb_audio_dac_serializer;
  localparam int SW    = 16;
  localparam int SL    = 32;
  localparam int DIV   = 2;
  localparam int BPER  = 2 * DIV;        // clks per BCLK period
  localparam int FRAME = 2 * SL * BPER;  // clks per stereo frame

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic aud_bclk, aud_daclrck, aud_dacdat, underrun;

  audio_dac_if #(.SAMPLE_WIDTH(SW)) bus();

  audio_dac_serializer #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SL), .BCLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .enable(enable), .aud_in(bus),
    .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck), .aud_dacdat(aud_dacdat),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // stimulus state
  logic        en_r, rst_r, src_v;
  logic [31:0] src_d;

  // reference model: frame position is plain clk count since start of run
  int          m_st;   // 0 idle, 1 run, 2 drain
  int          m_n;
  logic        m_rdy, m_acc, m_ur, m_buf_v;
  logic [31:0] m_buf, m_tx;

  // frame capture on BCLK rise
  logic        prev_bclk = 1'b0;
  logic        cap_on = 1'b0;
  logic [63:0] cap;
  int          cap_cnt;

  task automatic model_edge(input logic en_i, input logic v_i, input logic rst_i, input logic [31:0] d);
    logic bnd;
    m_acc = v_i & m_rdy;
    m_ur  = 1'b0;
    if (!rst_i) begin
      m_st = 0; m_n = 0; m_buf_v = 0; m_buf = '0; m_tx = '0; m_rdy = 1; m_acc = 0;
    end else begin
      if (m_st == 0) begin
        if (m_acc) begin m_tx = d; m_st = 1; m_n = 0; end
        else if (en_i && m_buf_v) begin m_tx = m_buf; m_buf_v = 0; m_st = 1; m_n = 0; end
      end else begin
        m_n++;
        bnd = (m_n % FRAME) == 0;
        if (bnd && m_st == 2 && !en_i) m_st = 0;
        else begin
          if (bnd) begin
            if (m_buf_v) begin m_tx = m_buf; m_buf_v = 0; end
            else m_ur = 1;
          end
          m_st = en_i ? 1 : 2;
        end
        if (m_acc) begin m_buf = d; m_buf_v = 1; end
      end
      m_rdy = en_i && !m_buf_v && m_st != 2;
    end
  endtask

  task automatic tick();
    logic e_bclk, e_lrck, e_dat;
    logic [15:0] smp;
    int b, k;
    bus.sample_valid   = src_v;
    bus.left_audio_in  = src_d[31:16];
    bus.right_audio_in = src_d[15:0];
    enable = en_r;
    rst    = rst_r;
    @(posedge clk);
    @(negedge clk);
    model_edge(en_r, src_v, rst_r, src_d);
    if (m_acc) src_v = 1'b0;
    e_bclk = 0; e_lrck = 0; e_dat = 0;
    if (m_st != 0) begin
      e_bclk = (m_n % BPER) >= DIV;
      b      = (m_n / BPER) % (2 * SL);
      e_lrck = b >= SL;
      k      = b % SL;
      smp    = e_lrck ? m_tx[15:0] : m_tx[31:16];
      if (k >= 1 && k <= SW) e_dat = smp[SW - k];
    end
    chk("bclk", aud_bclk, e_bclk);
    chk("lrck", aud_daclrck, e_lrck);
    chk("dat", aud_dacdat, e_dat);
    chk("underrun", underrun, m_ur);
    chk("ready", bus.sample_ready, m_rdy);
    if (cap_on && !prev_bclk && aud_bclk) begin
      cap = {cap[62:0], aud_dacdat};
      cap_cnt++;
    end
    prev_bclk = aud_bclk;
  endtask

  // permille chance per clk of offering a new sample when the source is free
  task automatic src_gen(input int vpm);
    if (!src_v && $urandom_range(999) < vpm) begin
      src_v = 1'b1;
      src_d = $urandom;
    end
  endtask

  task automatic run(input int cycles, input int vpm);
    for (int i = 0; i < cycles; i++) begin
      src_gen(vpm);
      tick();
    end
  endtask

  initial begin
    logic [63:0] exp_frame;
    int guard, cnt;
    en_r = 0; rst_r = 0; src_v = 0; src_d = '0;
    bus.sample_valid = 0; bus.left_audio_in = '0; bus.right_audio_in = '0;
    @(negedge clk);

    // reset state
    repeat (3) tick();
    chk("rst_bclk", aud_bclk, 0);
    chk("rst_lrck", aud_daclrck, 0);
    chk("rst_dat", aud_dacdat, 0);
    chk("rst_ur", underrun, 0);
    chk("rst_ready", bus.sample_ready, 1);
    rst_r = 1;

    // one known frame, then starve the buffer for underruns
    en_r = 1; src_v = 1; src_d = {16'hA5C3, 16'h8001};
    cap_on = 1; cap_cnt = 0; cap = '0;
    guard = 0;
    while (cap_cnt < 64 && guard < FRAME + 64) begin tick(); guard++; end
    cap_on = 0;
    exp_frame = {1'b0, 16'hA5C3, 15'h0, 1'b0, 16'h8001, 15'h0};
    chk("frame1", cap, exp_frame);
    cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin tick(); cnt += int'(underrun); end
    chk("starve_ur_cnt", cnt, 2);

    // backpressure: valid always asserted
    run(6 * FRAME, 1000);
    // sparse source: mix of underruns and fresh frames
    run(6 * FRAME, 5);

    // accept on a boundary clk with the buffer empty
    src_v = 0;
    guard = 0;
    while (!(m_st == 1 && !m_buf_v && ((m_n + 1) % FRAME) == 0) && guard < 3 * FRAME) begin
      tick(); guard++;
    end
    chk("bnd_wait", guard < 3 * FRAME, 1);
    src_v = 1; src_d = $urandom;
    tick();
    chk("bnd_ur", underrun, 1);
    chk("bnd_ready", bus.sample_ready, 0);
    run(2 * FRAME, 0);

    // disable at left-slot bit 10 with nothing buffered
    guard = 0;
    while (!(m_st == 1 && !m_buf_v && !src_v && ((m_n / BPER) % (2 * SL)) == 10 && (m_n % BPER) == 0)
           && guard < 3 * FRAME) begin
      tick(); guard++;
    end
    chk("dis_wait", guard < 3 * FRAME, 1);
    en_r = 0;
    tick();
    chk("dis_ready", bus.sample_ready, 0);
    cnt = 0; guard = 0;
    begin
      int ur_seen = 0;
      while (m_st != 0 && guard < FRAME + 8) begin
        tick(); guard++;
        ur_seen += int'(underrun);
        cnt += int'(aud_daclrck);
      end
      chk("dis_no_ur", ur_seen, 0);
    end
    chk("dis_done", guard < FRAME + 8, 1);
    chk("drain_rslot", cnt, SL * BPER);
    run(20, 0);
    chk("idle_bclk", aud_bclk, 0);
    chk("idle_lrck", aud_daclrck, 0);
    chk("idle_dat", aud_dacdat, 0);

    // restart, then reset in the middle of a frame
    en_r = 1;
    run(FRAME + 100, 1000);
    rst_r = 0;
    run(3, 1000);
    chk("rst2_bclk", aud_bclk, 0);
    chk("rst2_lrck", aud_daclrck, 0);
    chk("rst2_dat", aud_dacdat, 0);
    chk("rst2_ready", bus.sample_ready, 1);
    rst_r = 1;

    // random traffic with enable toggling
    for (int f = 0; f < 20; f++) begin
      int vpm = $urandom_range(20);
      if (f % 3 == 0) vpm = 1000;
      for (int i = 0; i < FRAME; i++) begin
        if ($urandom_range(999) == 0) en_r = ~en_r;
        src_gen(vpm);
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
